ring_pattern_gen: RTL

Generates bursts of rotating bit patterns. It is the upstream driver for the stimulus stage and feeds that stage's number[7:0] input.
- Loadable seed, selectable rotate direction, programmable burst length.
- Valid/ready handshake on the output side, so the downstream stage can stall the stream.
- Fits the bench-side stimulus path next to the existing stimulus module.

---
 rtl/ring_pattern_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/ring_pattern_gen.sv
// ring_pattern_gen: emits bursts of a rotating bit pattern on a valid/ready
// output. A seed can be loaded, the rotate direction is chosen per beat, and
// the burst length is programmable.
//
// Optional feature macro: RING_PATTERN_PARITY_EN
//   When defined, adds number_parity (XOR reduction of number_out) and
//   err_inject (inverts number_parity during a handshake beat).
//
// Handshake: a beat transfers on any rising edge where out_valid and out_ready
// are both 1. While out_valid = 1 and out_ready = 0, number_out and the
// remaining count hold steady. out_valid never drops until that beat transfers,
// except on reset.
module ring_pattern_gen #(
  parameter int               WIDTH         = 8,
  parameter int               LEN_W         = 8,
  parameter logic [WIDTH-1:0] RESET_PATTERN = WIDTH'(8'h01)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] number_out,
`ifdef RING_PATTERN_PARITY_EN
  output logic             number_parity,
  input  logic             err_inject,
`endif
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pattern, pattern_next;
  logic [LEN_W-1:0] remaining, remaining_next;
  logic             handshake;

  assign handshake = out_valid & out_ready;

  // State, pattern and beat counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pattern   <= RESET_PATTERN;
      remaining <= '0;
    end else begin
      state     <= state_next;
      pattern   <= pattern_next;
      remaining <= remaining_next;
    end
  end

  // Next-state logic: seed load and burst start in IDLE, rotate on each beat.
  always_comb begin
    state_next     = state;
    pattern_next   = pattern;
    remaining_next = remaining;
    case (state)
      IDLE: begin
        if (load) pattern_next = load_data;
        if (start) begin
          if (burst_len != '0) begin
            state_next     = RUN;
            remaining_next = burst_len;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (handshake) begin
          pattern_next   = dir ? {pattern[WIDTH-2:0], pattern[WIDTH-1]}
                               : {pattern[0], pattern[WIDTH-1:1]};
          remaining_next = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs decode directly from the state register.
  assign out_valid  = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign number_out = pattern;

`ifdef RING_PATTERN_PARITY_EN
  // Parity follows number_out in the same cycle; err_inject flips it only
  // for a beat that is actually transferring.
  assign number_parity = (^pattern) ^ (err_inject & handshake);
`endif

endmodule
